tuning_controller: RTL

TUNING_CONTROLLER -- requirements
Module: tuning_controller

---
 rtl/tuning_controller.sv | 135 +++++++++++++
 1 files changed

// File: rtl/tuning_controller.sv
// Retunes an NCO phase increment (direct or swept), muting the mixer for SETTLE_CYCLES after each load.
// Latency: phase_inc and phase_load change one edge after acceptance; done arrives after the final settle or dwell.
// Backpressure: cmd_ready is high only when IDLE and out of reset; commands offered while busy are ignored.
module tuning_controller #(
    parameter int PHASE_WIDTH   = 32,
    parameter int COUNT_WIDTH   = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_sweep,
    input  logic [PHASE_WIDTH-1:0] cmd_freq,
    input  logic [PHASE_WIDTH-1:0] cmd_step,
    input  logic [COUNT_WIDTH-1:0] cmd_count,
    input  logic [COUNT_WIDTH-1:0] cmd_dwell,
    input  logic                   abort,
    output logic [PHASE_WIDTH-1:0] phase_inc,
    output logic                   phase_load,
    output logic                   mix_enable,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {IDLE, SETTLE, DWELL} state_t;

    localparam logic [7:0]             SETTLE_INIT = 8'(SETTLE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);

    state_t                 state;
    state_t                 next_state;
    logic [7:0]             settle_cnt;
    logic [COUNT_WIDTH-1:0] dwell_cnt;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [COUNT_WIDTH-1:0] dwell_lat;
    logic [PHASE_WIDTH-1:0] step_lat;
    logic                   sweep_lat;
    logic                   accept;
    logic                   settle_done;
    logic                   dwell_done;

    assign accept      = cmd_valid & cmd_ready;
    assign settle_done = (settle_cnt == 8'd0);
    assign dwell_done  = (dwell_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // abort outranks every other exit from SETTLE/DWELL
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (accept) next_state = SETTLE;
            SETTLE: begin
                if (abort)            next_state = IDLE;
                else if (settle_done) next_state = sweep_lat ? DWELL : IDLE;
            end
            DWELL: begin
                if (abort)           next_state = IDLE;
                else if (dwell_done) next_state = (remaining == '0) ? IDLE : SETTLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        cmd_ready = (state == IDLE) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_inc  <= '0;
            phase_load <= 1'b0;
            mix_enable <= 1'b0;
            done       <= 1'b0;
            settle_cnt <= 8'd0;
            dwell_cnt  <= '0;
            remaining  <= '0;
            dwell_lat  <= '0;
            step_lat   <= '0;
            sweep_lat  <= 1'b0;
        end else begin
            phase_load <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        phase_inc  <= cmd_freq;
                        phase_load <= 1'b1;
                        mix_enable <= 1'b0;
                        step_lat   <= cmd_step;
                        remaining  <= cmd_count;
                        dwell_lat  <= cmd_dwell;
                        sweep_lat  <= cmd_sweep;
                        settle_cnt <= SETTLE_INIT;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        mix_enable <= 1'b1;
                    end else if (settle_done) begin
                        mix_enable <= 1'b1;
                        if (sweep_lat) dwell_cnt <= dwell_lat;
                        else           done      <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                DWELL: begin
                    if (abort) begin
                        mix_enable <= 1'b1;
                    end else if (dwell_done) begin
                        if (remaining == '0) begin
                            done <= 1'b1;
                        end else begin
                            phase_inc  <= phase_inc + step_lat;
                            remaining  <= remaining - CNT_ONE;
                            phase_load <= 1'b1;
                            mix_enable <= 1'b0;
                            settle_cnt <= SETTLE_INIT;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
